johnson_decoder: RTL and testbench

Receive-side companion to the team's Johnson counter: samples an N-bit Johnson code word, decodes it to a binary state index, checks it for legality and for correct step-by-one sequencing, and reports lock status and a saturating error count. Sits on any link or monitor point that carries a Johnson-coded state (e.g. a remote counter's outputs) and turns it into a checked binary value for downstream logic.

---
 rtl/johnson_decoder.sv | 133 +++++++++++++
 tb/tb_johnson_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/johnson_decoder.sv
// Johnson code word decoder: legality check, binary index, step-by-one lock tracker, saturating error count.
// Optional macro JOHNSON_DEC_HOLD_EN: a legal repeat of the previous word is accepted as a held state.
module johnson_decoder #(
  parameter  int N          = 4,
  parameter  int LOCK_COUNT = 3,
  parameter  int ERR_CNT_W  = 8,
  localparam int IW         = $clog2(2 * N)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 en,
  input  logic [N-1:0]         code_in,
  output logic [IW-1:0]        index,
  output logic                 valid_code,
  output logic                 locked,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RW = $clog2(LOCK_COUNT + 1);

`ifdef JOHNSON_DEC_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   have_q, have_d;
  logic [RW-1:0]          run_q, run_d;
  logic                   seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;

  int                     pop;
  int                     trans;
  logic                   legal;
  logic [IW-1:0]          dec;
  logic [IW-1:0]          expect_idx;
  logic                   is_step;
  logic                   is_repeat;
  logic                   err_bump;

  // A legal Johnson word has at most one boundary between a run of ones and a run of zeros.
  always_comb begin
    pop   = 0;
    trans = 0;
    for (int i = 0; i < N; i++) pop += int'(code_in[i]);
    for (int i = 0; i < N - 1; i++) trans += int'(code_in[i] ^ code_in[i+1]);
    legal = (trans <= 1);
    if (code_in[N-1])  dec = IW'(pop);
    else if (pop == 0) dec = '0;
    else               dec = IW'(2 * N - pop);
  end

  assign expect_idx = (index_q == IW'(2 * N - 1)) ? '0 : index_q + 1'b1;
  assign is_step    = have_q && (dec == expect_idx);
  assign is_repeat  = have_q && (dec == index_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    valid_d   = valid_q;
    have_d    = have_q;
    run_d     = run_q;
    err_d     = err_q;
    seq_err_d = 1'b0;
    err_bump  = 1'b0;

    if (en) begin
      valid_d = legal;
      if (!legal) begin
        have_d = 1'b0;
        run_d  = '0;
        if (state_q == LOCKED) begin
          err_bump = 1'b1;
          state_d  = UNLOCKED;
        end
      end else if (!(HOLD_EN && is_repeat)) begin
        index_d = dec;
        if (is_step) begin
          if (state_q == UNLOCKED) begin
            run_d = run_q + 1'b1;
            if (run_q + 1'b1 == RW'(LOCK_COUNT)) state_d = LOCKED;
          end
        end else begin
          // Mismatch or first word: resynchronise on the new index and restart the run.
          if (state_q == LOCKED) err_bump = 1'b1;
          state_d = UNLOCKED;
          run_d   = '0;
          have_d  = 1'b1;
        end
      end
    end

    if (err_bump) begin
      seq_err_d = 1'b1;
      if (err_q != '1) err_d = err_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= UNLOCKED;
      index_q   <= '0;
      valid_q   <= 1'b0;
      have_q    <= 1'b0;
      run_q     <= '0;
      seq_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      have_q    <= have_d;
      run_q     <= run_d;
      seq_err_q <= seq_err_d;
      err_q     <= err_d;
    end
  end

  assign index      = index_q;
  assign valid_code = valid_q;
  assign locked     = (state_q == LOCKED);
  assign seq_err    = seq_err_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: directed test-plan sequences then random traffic against a table-driven model.
module tb_johnson_decoder;

  localparam int N  = 4;
  localparam int LC = 3;
  localparam int EW = 2;
  localparam int IW = $clog2(2 * N);

`ifdef JOHNSON_DEC_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clear;
  logic          en;
  logic [N-1:0]  code_in;
  logic [IW-1:0] index;
  logic          valid_code;
  logic          locked;
  logic          seq_err;
  logic [EW-1:0] err_count;

  johnson_decoder #(.N(N), .LOCK_COUNT(LC), .ERR_CNT_W(EW)) dut (
    .clk        (clk),
    .clear      (clear),
    .en         (en),
    .code_in    (code_in),
    .index      (index),
    .valid_code (valid_code),
    .locked     (locked),
    .seq_err    (seq_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit valid;
    bit lock;
    bit serr;
    int errc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state, expressed in terms of state indices rather than registers.
  int m_idx = 0, m_run = 0, m_err = 0;
  bit m_valid = 0, m_locked = 0, m_have = 0;

  // Code word for index k, built straight from the sequence definition.
  function automatic logic [N-1:0] code_of(int k);
    logic [N-1:0] c = '0;
    for (int b = 0; b < N; b++)
      if ((k <= N) ? (b < k) : (b >= k - N)) c[N-1-b] = 1'b1;
    return c;
  endfunction

  task automatic drive(input bit c, input bit e, input logic [N-1:0] w);
    int   k = -1;
    bit   serr = 1'b0;
    exp_t x;
    @(negedge clk);
    clear   = c;
    en      = e;
    code_in = w;
    for (int j = 0; j < 2 * N; j++) if (code_of(j) == w) k = j;
    if (c) begin
      m_idx = 0; m_run = 0; m_err = 0;
      m_valid = 0; m_locked = 0; m_have = 0;
    end else if (e) begin
      if (k >= 0) begin
        m_valid = 1;
        if (!(HOLD && m_have && k == m_idx)) begin
          if (m_have && k == (m_idx + 1) % (2 * N)) begin
            if (!m_locked) begin
              m_run++;
              if (m_run == LC) m_locked = 1;
            end
          end else begin
            if (m_locked) begin serr = 1; m_locked = 0; end
            m_run  = 0;
            m_have = 1;
          end
          m_idx = k;
        end
      end else begin
        m_valid = 0;
        m_have  = 0;
        m_run   = 0;
        if (m_locked) begin serr = 1; m_locked = 0; end
      end
      if (serr && m_err < (1 << EW) - 1) m_err++;
    end
    x.idx = m_idx; x.valid = m_valid; x.lock = m_locked; x.serr = serr; x.errc = m_err;
    sb_q.push_back(x);
  endtask

  task automatic words(input logic [N-1:0] ws[$]);
    foreach (ws[i]) drive(1'b0, 1'b1, ws[i]);
  endtask

  // Monitor: each edge's registered result is compared against the oldest pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        vectors++;
        if (index !== IW'(x.idx) || valid_code !== x.valid || locked !== x.lock ||
            seq_err !== x.serr || err_count !== EW'(x.errc)) begin
          miscompares++;
          $display("FAIL vec%0d: got idx=%0d valid=%0b locked=%0b seq_err=%0b err=%0d, expected idx=%0d valid=%0b locked=%0b seq_err=%0b err=%0d",
                   vectors, index, valid_code, locked, seq_err, err_count,
                   x.idx, x.valid, x.lock, x.serr, x.errc);
        end
      end
    end
  end

  initial begin
    int r;
    int budget;
    clear = 1'b1; en = 1'b0; code_in = '0;
    drive(1'b1, 1'b0, 4'b0000);
    // Acquire lock, then walk through the wrap.
    words('{4'b0000, 4'b1000, 4'b1100, 4'b1110});
    words('{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100});
    // Skip-ahead while locked, then relock.
    words('{4'b1111, 4'b0111, 4'b0011, 4'b0001});
    words('{4'b0000, 4'b1000, 4'b1100});
    // Illegal word while locked, then again while unlocked.
    words('{4'b1010, 4'b1010});
    words('{4'b0000, 4'b1000, 4'b1100, 4'b1110});
    // Enable gaps, then a repeat of the held word.
    repeat (3) drive(1'b0, 1'b0, 4'b0101);
    words('{4'b1110});
    // Enable gaps between correct steps keep lock.
    words('{4'b0000, 4'b1000, 4'b1100, 4'b1110});
    drive(1'b0, 1'b0, 4'b0000);
    words('{4'b1111});
    drive(1'b0, 1'b0, 4'b1001);
    words('{4'b0111});
    // Repeated lock/error cycles to reach saturation.
    repeat (5) begin
      words('{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b0011});
    end
    // Random traffic biased towards correct steps.
    repeat (2000) begin
      r = $urandom_range(0, 99);
      if (r < 2)       drive(1'b1, 1'(($urandom)), 4'($urandom));
      else if (r < 12) drive(1'b0, 1'b0, 4'($urandom));
      else if (r < 20) drive(1'b0, 1'b1, 4'($urandom));
      else if (r < 27) drive(1'b0, 1'b1, code_of(m_idx));
      else if (r < 35) drive(1'b0, 1'b1, code_of(int'($urandom_range(0, 2 * N - 1))));
      else             drive(1'b0, 1'b1, code_of((m_idx + 1) % (2 * N)));
    end
    // Clear while locked returns everything to reset values.
    words('{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111});
    drive(1'b1, 1'b1, 4'b0111);
    drive(1'b0, 1'b0, 4'b0000);

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
